serial_parity_tx: RTL and testbench
===================================

SERIAL_PARITY_TX -- requirements
Module: serial_parity_tx

Interface
REQ-001 The module SHALL have parameter DATA_BITS, default 8, which sets the number of data bits per frame; legal values are 2..32.
REQ-002 The module SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, width 1: synchronous, active-high reset.
REQ-004 The module SHALL have port data_in, input, width DATA_BITS: parallel word to transmit, sampled only on accept.
REQ-005 The module SHALL have port load, input, width 1: request to transmit data_in.
REQ-006 The module SHALL have port ready, output, width 1: high only in IDLE; a word is accepted in any cycle where load && ready.
REQ-007 The module SHALL have port serial_out, output, width 1: the serial bit stream consumed by the downstream even-parity checker.
REQ-008 The module SHALL have port frame_active, output, width 1: high while serial_out carries a data or parity bit.
REQ-009 The module SHALL have port bit_last, output, width 1: high only in the cycle serial_out carries the parity bit.

Function
REQ-010 The FSM SHALL have the states IDLE, DATA and PARITY.
REQ-011 In IDLE, on accept, the module SHALL capture data_in into a shift register, clear the bit counter, clear the running parity and move to DATA.
REQ-012 In DATA, the module SHALL drive one bit per cycle on serial_out, LSB first, and XOR each bit into the running parity.
REQ-013 After DATA_BITS cycles in DATA, the module SHALL move to PARITY.
REQ-014 In PARITY, serial_out SHALL equal the XOR of all data bits, so the frame contains an even number of 1s; the module then returns to IDLE.
REQ-015 serial_out, frame_active and bit_last SHALL be registered: the first data bit appears in cycle N+1 after an accept in cycle N, and the parity bit appears in cycle N+DATA_BITS+1.
REQ-016 In IDLE, serial_out, frame_active and bit_last SHALL be 0; idle cycles are neutral to the downstream parity state.
REQ-017 The module SHALL ignore load while ready=0, and SHALL NOT sample data_in in that case.
REQ-018 The minimum frame period SHALL be DATA_BITS+2 cycles (accept, data bits, parity); with load held high, the next accept occurs in the IDLE cycle immediately after PARITY.
REQ-019 The bit counter SHALL be $clog2(DATA_BITS) bits wide and SHALL never wrap within a frame.

Reset
REQ-020 While reset=1, the module SHALL go to IDLE with ready=1, serial_out=0, frame_active=0, bit_last=0, counter=0 and parity=0.
REQ-021 Reset SHALL take priority over load.
REQ-022 A reset in the middle of a frame SHALL abort the frame: no further bits of it are sent, and the next frame after reset is transmitted correctly.

Configuration
REQ-023 With macro SERIAL_PARITY_TX_ERR_INJECT_EN defined, the module SHALL add port inject_err, input, width 1, sampled on accept; if it was 1, the parity bit of that frame SHALL be inverted.
REQ-024 Without SERIAL_PARITY_TX_ERR_INJECT_EN, the inject_err port SHALL be absent and the parity bit SHALL always be even parity.

Structure
REQ-025 Package parity_pkg SHALL hold typedef enum tx_state_t {IDLE, DATA, PARITY} and the constant DEFAULT_DATA_BITS = 8.
REQ-026 The block SHALL be a single module with no sub-module; parity accumulation is inline.

Verification (DATA_BITS=8)
REQ-027 Scenario: reset held 2 cycles -> ready=1, serial_out=0, frame_active=0, bit_last=0.
REQ-028 Scenario: accept 8'hA5 -> serial_out 1,0,1,0,0,1,0,1 then parity 0; frame_active high for 9 cycles; bit_last only on the 9th.
REQ-029 Scenario: accept 8'h07 -> serial_out 1,1,1,0,0,0,0,0 then parity 1; the downstream checker ends the frame in its even-parity state.
REQ-030 Scenario: load held high with 8'h01, then data_in changed to 8'h03 mid-frame -> the first frame sends 8'h01 unchanged with parity 1; the second frame is accepted exactly 10 cycles after the first and sends 8'h03 with parity 0.
REQ-031 Scenario: reset asserted during the 4th data bit of 8'hFF -> next cycle serial_out=0 and ready=1; a following 8'h0F frame gives parity 0.
REQ-032 Scenario: macro defined, inject_err=1 with 8'hA5 -> parity bit 1 and the downstream checker output = 1; with inject_err=0 the parity bit is 0.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared types and constants for the serial even-parity transmitter.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } tx_state_t;

  localparam int DEFAULT_DATA_BITS = 8;

endpackage

// File: rtl/serial_parity_tx.sv
// Serial transmitter: DATA_BITS data bits LSB first, then one even-parity bit.
// Optional macro SERIAL_PARITY_TX_ERR_INJECT_EN adds inject_err to invert a frame's parity bit.
//
// state  | meaning
// IDLE   | ready for a word; outputs neutral (all 0)
// DATA   | shifting data bits out, accumulating parity
// PARITY | parity bit on serial_out; back to IDLE next
module serial_parity_tx
  import parity_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 load,
`ifdef SERIAL_PARITY_TX_ERR_INJECT_EN
  input  logic                 inject_err,
`endif
  output logic                 ready,
  output logic                 serial_out,
  output logic                 frame_active,
  output logic                 bit_last
);

  localparam int CNT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_BITS - 1);

  tx_state_t            state, state_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 par, par_nxt;
  logic                 so_nxt, fa_nxt, bl_nxt;
`ifdef SERIAL_PARITY_TX_ERR_INJECT_EN
  logic                 inj_q, inj_nxt;
`endif

  assign ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      shift        <= '0;
      cnt          <= '0;
      par          <= 1'b0;
      serial_out   <= 1'b0;
      frame_active <= 1'b0;
      bit_last     <= 1'b0;
`ifdef SERIAL_PARITY_TX_ERR_INJECT_EN
      inj_q        <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      shift        <= shift_nxt;
      cnt          <= cnt_nxt;
      par          <= par_nxt;
      serial_out   <= so_nxt;
      frame_active <= fa_nxt;
      bit_last     <= bl_nxt;
`ifdef SERIAL_PARITY_TX_ERR_INJECT_EN
      inj_q        <= inj_nxt;
`endif
    end
  end

  // Outputs are computed one cycle ahead so the registered serial_out
  // shows shift[0] during each DATA cycle and the parity during PARITY.
  always_comb begin
    state_nxt = state;
    shift_nxt = shift;
    cnt_nxt   = cnt;
    par_nxt   = par;
    so_nxt    = 1'b0;
    fa_nxt    = 1'b0;
    bl_nxt    = 1'b0;
`ifdef SERIAL_PARITY_TX_ERR_INJECT_EN
    inj_nxt   = inj_q;
`endif
    case (state)
      IDLE: begin
        if (load) begin
          state_nxt = DATA;
          shift_nxt = data_in;
          cnt_nxt   = '0;
          par_nxt   = 1'b0;
          so_nxt    = data_in[0];
          fa_nxt    = 1'b1;
`ifdef SERIAL_PARITY_TX_ERR_INJECT_EN
          inj_nxt   = inject_err;
`endif
        end
      end
      DATA: begin
        par_nxt   = par ^ shift[0];
        shift_nxt = shift >> 1;
        fa_nxt    = 1'b1;
        if (cnt == LAST_CNT) begin
          state_nxt = PARITY;
          bl_nxt    = 1'b1;
`ifdef SERIAL_PARITY_TX_ERR_INJECT_EN
          so_nxt    = par ^ shift[0] ^ inj_q;
`else
          so_nxt    = par ^ shift[0];
`endif
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
          so_nxt  = shift[1];
        end
      end
      PARITY: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_parity_tx.sv
// Self-checking bench for serial_parity_tx (DATA_BITS=8): table-driven frames
// checked through an expected-bit scoreboard, plus held-load and mid-frame reset sequences.
module tb_serial_parity_tx;

  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DB-1:0] data_in;
  logic          load;
  logic          inject_err;
  logic          ready, serial_out, frame_active, bit_last;

  serial_parity_tx #(.DATA_BITS(DB)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .load         (load),
`ifdef SERIAL_PARITY_TX_ERR_INJECT_EN
    .inject_err   (inject_err),
`endif
    .ready        (ready),
    .serial_out   (serial_out),
    .frame_active (frame_active),
    .bit_last     (bit_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DB-1:0] data;
    logic          inj;
    logic          par;
  } vec_t;

  typedef struct {
    logic so;
    logic last;
    logic chk;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  bit   mon_en = 1'b0;
  logic chk_par = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic inj_eff(input logic inj);
`ifdef SERIAL_PARITY_TX_ERR_INJECT_EN
    return inj;
`else
    return 1'b0;
`endif
  endfunction

  task automatic push_frame(input logic [DB-1:0] d, input logic inj, input logic par);
    exp_t e;
    for (int i = 0; i < DB; i++) begin
      e.so = d[i]; e.last = 1'b0; e.chk = 1'b0;
      exp_q.push_back(e);
    end
    e.so = par ^ inj_eff(inj); e.last = 1'b1; e.chk = inj_eff(inj);
    exp_q.push_back(e);
  endtask

  always @(posedge clk) cyc++;

  // Monitor: pops expected bits while frame_active, models the downstream checker.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (load && ready && !reset) acc_q.push_back(cyc);
      if (frame_active) begin
        if (exp_q.size() == 0) begin
          check("unexpected_bit", 32'(frame_active), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("serial_out", 32'(serial_out), 32'(e.so));
          check("bit_last", 32'(bit_last), 32'(e.last));
          chk_par = chk_par ^ serial_out;
          if (e.last) begin
            check("checker_out", 32'(chk_par), 32'(e.chk));
            chk_par = 1'b0;
          end
        end
      end else begin
        check("idle_out", {30'd0, serial_out, bit_last}, 32'd0);
      end
      if (reset) begin
        exp_q.delete();
        chk_par = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 50) begin tick(); n++; end
    if (!ready) check("ready_timeout", 32'(ready), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || !ready) && n < 40) begin tick(); n++; end
    check("frame_done", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic send(input logic [DB-1:0] d, input logic inj, input logic par);
    wait_ready();
    push_frame(d, inj, par);
    data_in = d; inject_err = inj; load = 1'b1;
    tick();
    load = 1'b0; data_in = ~d; inject_err = ~inj;
    check("ready_busy", 32'(ready), 32'd0);
  endtask

  vec_t tbl[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{data: 8'hA5, inj: 1'b0, par: 1'b0};
    tbl[1] = '{data: 8'h07, inj: 1'b0, par: 1'b1};
    tbl[2] = '{data: 8'h00, inj: 1'b0, par: 1'b0};
    tbl[3] = '{data: 8'hFF, inj: 1'b0, par: 1'b0};
    tbl[4] = '{data: 8'h80, inj: 1'b0, par: 1'b1};
    tbl[5] = '{data: 8'h7F, inj: 1'b0, par: 1'b1};
    tbl[6] = '{data: 8'h3C, inj: 1'b0, par: 1'b0};
    tbl[7] = '{data: 8'hA5, inj: 1'b1, par: 1'b0};

    reset = 1'b1; load = 1'b1; data_in = 8'hFF; inject_err = 1'b0;
    tick(); tick();
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_serial_out", 32'(serial_out), 32'd0);
    check("rst_frame_active", 32'(frame_active), 32'd0);
    check("rst_bit_last", 32'(bit_last), 32'd0);
    load = 1'b0;
    reset = 1'b0;
    mon_en = 1'b1;
    tick();

    foreach (tbl[i]) begin
      send(tbl[i].data, tbl[i].inj, tbl[i].par);
      wait_idle();
      tick();
    end

    // Held load: second accept exactly DB+2 cycles after the first; data change mid-frame ignored.
    acc_q.delete();
    push_frame(8'h01, 1'b0, 1'b1);
    push_frame(8'h03, 1'b0, 1'b0);
    inject_err = 1'b0; data_in = 8'h01; load = 1'b1;
    for (int n = 0; n < 4; n++) tick();
    data_in = 8'h03;
    for (int n = 0; n < 30 && acc_q.size() < 2; n++) tick();
    load = 1'b0;
    check("held_accepts", 32'(acc_q.size()), 32'd2);
    if (acc_q.size() >= 2) check("held_period", 32'(acc_q[1] - acc_q[0]), 32'(DB + 2));
    wait_idle();
    tick();

    // Reset during the 4th data bit aborts the frame.
    send(8'hFF, 1'b0, 1'b0);
    tick(); tick(); tick();
    check("abort_mid_frame", 32'(frame_active), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_serial_out", 32'(serial_out), 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_frame_active", 32'(frame_active), 32'd0);
    send(8'h0F, 1'b0, 1'b0);
    wait_idle();
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
